byte_serial_tx: RTL and testbench

- Transmit end for the 8-bit data registers: accepts one byte over a valid/ready handshake and shifts it out on a single serial line, LSB first.
- Frame format: start bit 0, 8 data bits, stop bit 1.
- Sits between a byte-wide datapath register bank and the serial output pin.
- A matching receiver samples the same frame format.

---
 rtl/byte_serial_tx_pkg.sv | 17 +
 rtl/byte_serial_tx_bit_timer.sv | 40 ++++
 rtl/byte_serial_tx.sv | 109 ++++++++++
 tb/tb_byte_serial_tx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/byte_serial_tx_pkg.sv
// Shared definitions for the byte-serial transmitter and its matching receiver.
// Holds the FSM state encoding, the frame geometry and the counter widths.
package byte_serial_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StStart = 2'b01,
    StData  = 2'b10,
    StStop  = 2'b11
  } tx_state_e;

  localparam int unsigned FrameBits = 10;  // start + 8 data + stop
  localparam int unsigned DataBits  = 8;
  localparam int unsigned TickW     = 8;   // tick counter width, ClksPerBit <= 255
  localparam int unsigned BitCntW   = 3;   // indexes the 8 data bits

endpackage

// File: rtl/byte_serial_tx_bit_timer.sv
// Bit-period timer shared by the serial transmitter and receiver.
// Counts clock cycles inside one serial bit and flags the last one.
//   clk      : system clock
//   clear    : asynchronous active-high reset
//   run      : count while high; counter is held at 0 while low
//   bit_end  : high on the last cycle of each ClksPerBit-cycle bit period
module byte_serial_tx_bit_timer
  import byte_serial_tx_pkg::*;
#(
  parameter int unsigned ClksPerBit = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  output logic bit_end
);

  localparam logic [TickW-1:0] TickLast = TickW'(ClksPerBit - 1);

  logic [TickW-1:0] tick_q, tick_d;

  // With ClksPerBit == 1 TickLast is 0, so every running cycle is a bit end.
  assign bit_end = run & (tick_q == TickLast);

  always_comb begin
    tick_d = '0;
    if (run && !bit_end) begin
      tick_d = tick_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/byte_serial_tx.sv
// Byte-serial transmitter: accepts one byte over a valid/ready handshake and
// sends it LSB first as a frame of start bit (0), 8 data bits, stop bit (1).
//   clk      : system clock, rising edge
//   clear    : asynchronous active-high reset
//   d_valid  : upstream byte available
//   d_in     : byte to send, sampled only on the accept edge
//   d_ready  : block can accept a byte (idle)
//   tx       : registered serial line, idles high
//   busy     : frame in progress
//   done     : registered one-cycle pulse after the stop bit completes
module byte_serial_tx
  import byte_serial_tx_pkg::*;
#(
  parameter int unsigned ClksPerBit = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       d_valid,
  input  logic [7:0] d_in,
  output logic       d_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  tx_state_e          state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic               bit_end;

  byte_serial_tx_bit_timer #(
    .ClksPerBit (ClksPerBit)
  ) u_bit_timer (
    .clk     (clk),
    .clear   (clear),
    .run     (state_q != StIdle),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        if (d_valid) begin
          shift_d = d_in;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == BitCntW'(DataBits - 1)) begin
            bit_cnt_d = '0;
            state_d   = StStop;
            tx_d      = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            // Next LSB is shift_q[1]; drive it on the same edge the shift happens.
            tx_d      = shift_q[1];
          end
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (bit_end) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  assign d_ready = (state_q == StIdle);
  assign busy    = (state_q != StIdle);
  assign tx      = tx_q;
  assign done    = done_q;

endmodule

// File: tb/tb_byte_serial_tx.sv
// Self-checking bench for byte_serial_tx: one instance with 4 clocks per bit,
// one with 1 clock per bit, a frame-position reference model per instance,
// directed scenarios with literal expectations and a randomized phase.
module tb_byte_serial_tx;

  localparam int C0 = 4;
  localparam int C1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear0, dv0, rdy0, tx0, busy0, done0;
  logic [7:0] din0;
  logic       clear1, dv1, rdy1, tx1, busy1, done1;
  logic [7:0] din1;

  byte_serial_tx #(.ClksPerBit(C0)) dut0 (
    .clk(clk), .clear(clear0), .d_valid(dv0), .d_in(din0),
    .d_ready(rdy0), .tx(tx0), .busy(busy0), .done(done0)
  );

  byte_serial_tx #(.ClksPerBit(C1)) dut1 (
    .clk(clk), .clear(clear1), .d_valid(dv1), .d_in(din1),
    .d_ready(rdy1), .tx(tx1), .busy(busy1), .done(done1)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit idx of a frame: 0 = start, 1..8 = data LSB first, 9 = stop.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // Reference model: in_frame with position k cycles after the accept edge.
  bit         m0_in = 1'b0, m0_done = 1'b0;
  int         m0_k = 0;
  logic [7:0] m0_b = 8'h00;
  bit         m1_in = 1'b0, m1_done = 1'b0;
  int         m1_k = 0;
  logic [7:0] m1_b = 8'h00;

  always @(posedge clk or posedge clear0) begin
    if (clear0) begin
      m0_in <= 1'b0; m0_k <= 0; m0_done <= 1'b0;
    end else if (!m0_in) begin
      m0_done <= 1'b0;
      if (dv0) begin m0_in <= 1'b1; m0_k <= 0; m0_b <= din0; end
    end else begin
      m0_done <= 1'b0;
      if (m0_k + 1 == 10 * C0) begin m0_in <= 1'b0; m0_k <= 0; m0_done <= 1'b1; end
      else m0_k <= m0_k + 1;
    end
  end

  always @(posedge clk or posedge clear1) begin
    if (clear1) begin
      m1_in <= 1'b0; m1_k <= 0; m1_done <= 1'b0;
    end else if (!m1_in) begin
      m1_done <= 1'b0;
      if (dv1) begin m1_in <= 1'b1; m1_k <= 0; m1_b <= din1; end
    end else begin
      m1_done <= 1'b0;
      if (m1_k + 1 == 10 * C1) begin m1_in <= 1'b0; m1_k <= 0; m1_done <= 1'b1; end
      else m1_k <= m1_k + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m0_tx", tx0, m0_in ? frame_bit(m0_b, m0_k / C0) : 1'b1);
      chk("m0_busy", busy0, m0_in);
      chk("m0_ready", rdy0, !m0_in);
      chk("m0_done", done0, m0_done);
      chk("m1_tx", tx1, m1_in ? frame_bit(m1_b, m1_k / C1) : 1'b1);
      chk("m1_busy", busy1, m1_in);
      chk("m1_ready", rdy1, !m1_in);
      chk("m1_done", done1, m1_done);
    end
  end

  logic rec [40];
  logic pat_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  logic pat_3c [8]  = '{0, 0, 1, 1, 1, 1, 0, 0};
  logic pat_81 [10] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 1};
  logic pat_5a [10] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1};
  int   busy_cnt, t_first, t_second;
  bit   pend0, pend1;

  task automatic chk_async_reset(input string name);
    chk({name, "_tx"}, tx0, 1'b1);
    chk({name, "_busy"}, busy0, 1'b0);
    chk({name, "_ready"}, rdy0, 1'b1);
    chk({name, "_done"}, done0, 1'b0);
  endtask

  initial begin
    clear0 = 1'b0; clear1 = 1'b0; dv0 = 1'b0; dv1 = 1'b0; din0 = 8'h00; din1 = 8'h00;
    #1 clear0 = 1'b1; clear1 = 1'b1;
    #1 chk_async_reset("por");
    @(negedge clk);
    clear0 = 1'b0; clear1 = 1'b0;
    cmp_en = 1'b1;

    // 8'hA5 frame, with 8'h3C offered 5 cycles into it.
    @(negedge clk); dv0 = 1'b1; din0 = 8'hA5;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rec[i] = tx0;
      if (busy0) busy_cnt++;
      if (i == 0) dv0 = 1'b0;
      if (i == 4) begin dv0 = 1'b1; din0 = 8'h3C; end
    end
    @(negedge clk);
    chk("a5_busy_cycles", busy_cnt, 40);
    chk("a5_done", done0, 1'b1);
    chk("a5_ready_on_done", rdy0, 1'b1);
    for (int b = 0; b < 10; b++)
      for (int j = 0; j < C0; j++)
        chk($sformatf("a5_bit%0d", b), rec[C0*b+j], pat_a5[b]);

    // 8'h3C accepted on the done cycle.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rec[i] = tx0;
      if (i == 0) begin chk("3c_accept_on_done", busy0, 1'b1); dv0 = 1'b0; end
    end
    @(negedge clk);
    chk("3c_done", done0, 1'b1);
    for (int b = 0; b < 8; b++) chk($sformatf("3c_data%0d", b), rec[C0*(b+1)+2], pat_3c[b]);

    // Back-to-back 8'h00 then 8'hFF with d_valid held.
    @(negedge clk); dv0 = 1'b1; din0 = 8'h00;
    t_first = -1; t_second = -1;
    for (int cyc = 0; cyc < 200 && t_second < 0; cyc++) begin
      if (dv0 && rdy0) begin
        if (t_first < 0) t_first = cyc;
        else t_second = cyc;
      end
      @(negedge clk);
      if (t_first >= 0 && t_second < 0) din0 = 8'hFF;
    end
    dv0 = 1'b0;
    chk("b2b_spacing", t_second - t_first, 41);
    repeat (42) @(negedge clk);

    // 8'h5A aborted by clear in DATA, then 8'h81.
    dv0 = 1'b1; din0 = 8'h5A;
    @(negedge clk); dv0 = 1'b0;
    repeat (16) @(negedge clk);
    chk("5a_busy_before_clear", busy0, 1'b1);
    @(posedge clk); #2 clear0 = 1'b1;
    #1 chk_async_reset("midframe_clear");
    @(negedge clk);
    chk("clear_no_done", done0, 1'b0);
    clear0 = 1'b0; dv0 = 1'b1; din0 = 8'h81;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      rec[i] = tx0;
      if (i == 0) begin chk("81_accept_after_clear", busy0, 1'b1); dv0 = 1'b0; end
    end
    @(negedge clk);
    chk("81_done", done0, 1'b1);
    for (int b = 0; b < 10; b++) chk($sformatf("81_bit%0d", b), rec[C0*b+1], pat_81[b]);

    // One clock per bit: 8'h5A, then 8'hC3 accepted on the done cycle.
    dv1 = 1'b1; din1 = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rec[i] = tx1;
      if (i == 0) din1 = 8'hC3;
    end
    @(negedge clk);
    chk("c1_done", done1, 1'b1);
    chk("c1_ready_on_done", rdy1, 1'b1);
    @(negedge clk);
    chk("c1_accept_on_done", busy1, 1'b1);
    dv1 = 1'b0;
    for (int b = 0; b < 10; b++) chk($sformatf("c1_bit%0d", b), rec[b], pat_5a[b]);
    repeat (12) @(negedge clk);

    // Randomized traffic on both instances, with occasional clears on instance 0.
    pend0 = 1'b0; pend1 = 1'b0;
    fork
      begin
        for (int n = 0; n < 3000; n++) begin
          @(negedge clk);
          if (pend0) begin dv0 = ($urandom_range(0, 2) != 0); din0 = 8'($urandom); pend0 = 1'b0; end
          else if (!dv0) begin dv0 = ($urandom_range(0, 3) == 0); din0 = 8'($urandom); end
          pend0 = dv0 && rdy0;
          if ($urandom_range(0, 299) == 0) begin
            @(posedge clk); #2 clear0 = 1'b1;
            #1 chk_async_reset("rand_clear");
            @(negedge clk); clear0 = 1'b0;
          end
        end
      end
      begin
        for (int n = 0; n < 3000; n++) begin
          @(negedge clk);
          if (pend1) begin dv1 = ($urandom_range(0, 2) != 0); din1 = 8'($urandom); pend1 = 1'b0; end
          else if (!dv1) begin dv1 = ($urandom_range(0, 3) == 0); din1 = 8'($urandom); end
          pend1 = dv1 && rdy1;
        end
      end
    join
    dv0 = 1'b0; dv1 = 1'b0;
    repeat (50) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
